// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_pkg
// Purpose  : Shared constants for the 7-segment scan display slice.
//            - SEG_PATTERNS : active-high a..g patterns for hex 0..F,
//                             bit 6 = a ... bit 0 = g
//            - SEG_BLANK    : all segments and the decimal point dark
//                             (the bus is active-low)
//            - EN_ALL_OFF   : all digit enables inactive (active-low), sized
//                             for the largest bank; users slice the low
//                             NUM_DIGITS bits
// Revision : 1.0 - initial release
// ============================================================================
package seg_pkg;

    localparam int SEG_MAX_DIGITS = 8;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [SEG_MAX_DIGITS-1:0] EN_ALL_OFF = {SEG_MAX_DIGITS{1'b1}};

    localparam logic [6:0] SEG_PAT_0 = 7'h7E;
    localparam logic [6:0] SEG_PAT_1 = 7'h30;
    localparam logic [6:0] SEG_PAT_2 = 7'h6D;
    localparam logic [6:0] SEG_PAT_3 = 7'h79;
    localparam logic [6:0] SEG_PAT_4 = 7'h33;
    localparam logic [6:0] SEG_PAT_5 = 7'h5B;
    localparam logic [6:0] SEG_PAT_6 = 7'h5F;
    localparam logic [6:0] SEG_PAT_7 = 7'h70;
    localparam logic [6:0] SEG_PAT_8 = 7'h7F;
    localparam logic [6:0] SEG_PAT_9 = 7'h7B;
    localparam logic [6:0] SEG_PAT_A = 7'h77;
    localparam logic [6:0] SEG_PAT_B = 7'h1F;
    localparam logic [6:0] SEG_PAT_C = 7'h4E;
    localparam logic [6:0] SEG_PAT_D = 7'h3D;
    localparam logic [6:0] SEG_PAT_E = 7'h4F;
    localparam logic [6:0] SEG_PAT_F = 7'h47;

    // Entry 15 is the left-most element, so SEG_PATTERNS[n] is nibble n.
    localparam logic [15:0][6:0] SEG_PATTERNS = {
        SEG_PAT_F, SEG_PAT_E, SEG_PAT_D, SEG_PAT_C,
        SEG_PAT_B, SEG_PAT_A, SEG_PAT_9, SEG_PAT_8,
        SEG_PAT_7, SEG_PAT_6, SEG_PAT_5, SEG_PAT_4,
        SEG_PAT_3, SEG_PAT_2, SEG_PAT_1, SEG_PAT_0
    };

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_decode
// Purpose  : Combinational hex-to-7-segment decoder.
// Ports    : nibble  [3:0] in  - hex digit 0..F
//            pattern [6:0] out - active-high segments, [6]=a ... [0]=g
// Revision : 1.0 - initial release
// ============================================================================
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    assign pattern = SEG_PATTERNS[nibble];

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_driver
// Purpose  : Time-multiplexes NUM_DIGITS hex nibbles onto a common-anode
//            7-segment bank. Inputs are captured once per scan frame, each
//            digit slot begins with one blank guard cycle, and all outputs
//            are registered.
// Ports    : clk       in  - system clock
//            rst       in  - asynchronous active-high reset
//            digits    in  - packed nibbles, digit i = digits[4i+3:4i]
//            digit_en  in  - 1 = digit i lit
//            dp        in  - 1 = decimal point of digit i lit
//            led_en    out - active-low digit select (at most one bit low)
//            led_seg   out - active-low segments, [7]=a ... [1]=g, [0]=dp
// Options  : SEG_LEAD_ZERO_BLANK_EN - when defined, leading zero digits
//            (index > 0) are blanked at the frame latch.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 100000,
    parameter int DIV_W      = 17
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   dp,
    output logic [NUM_DIGITS-1:0]   led_en,
    output logic [7:0]              led_seg
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [DIV_W-1:0]      c_div_last = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]      c_idx_last = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] c_en_off   = EN_ALL_OFF[NUM_DIGITS-1:0];

    logic [DIV_W-1:0]        r_div_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_digits_q;
    logic [NUM_DIGITS-1:0]   r_en_q;
    logic [NUM_DIGITS-1:0]   r_dp_q;

    logic                    w_tick;
    logic                    w_frame;
    logic [3:0]              w_nibble;
    logic [6:0]              w_pattern;
    logic [NUM_DIGITS-1:0]   w_sel;
    logic [NUM_DIGITS-1:0]   w_en_load;

    assign w_tick   = (r_div_cnt == c_div_last);
    // Frame boundary: the last slot of the last digit is ending, so the
    // fresh snapshot becomes visible starting with digit 0.
    assign w_frame  = w_tick && (r_idx == c_idx_last);
    assign w_nibble = r_digits_q[{r_idx, 2'b00} +: 4];
    assign w_sel    = NUM_DIGITS'(1) << r_idx;

    seg7_decode u_decode (
        .nibble  (w_nibble),
        .pattern (w_pattern)
    );

`ifdef SEG_LEAD_ZERO_BLANK_EN
    logic w_lead;

    // Walk from the most significant digit down. w_lead stays set while every
    // digit seen so far is zero or disabled; a zero nibble under that
    // condition is a leading zero. Digit 0 is never examined, so it always
    // shows.
    always_comb begin
        w_en_load = digit_en;
        w_lead    = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (w_lead && (digits[4*i +: 4] == 4'h0)) begin
                w_en_load[i] = 1'b0;
            end
            w_lead = w_lead && ((digits[4*i +: 4] == 4'h0) || !digit_en[i]);
        end
    end
`else
    always_comb begin
        w_en_load = digit_en;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt  <= '0;
            r_idx      <= '0;
            r_digits_q <= '0;
            r_en_q     <= '0;
            r_dp_q     <= '0;
            led_en     <= c_en_off;
            led_seg    <= SEG_BLANK;
        end else begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;

            if (w_tick) begin
                r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
            end

            if (w_frame) begin
                r_digits_q <= digits;
                r_en_q     <= w_en_load;
                r_dp_q     <= dp;
            end

            // Outputs reflect the current slot state one cycle later. The
            // first cycle of every slot is blanked so the previous digit's
            // segments never appear under the next digit's enable.
            if ((r_div_cnt == '0) || !r_en_q[r_idx]) begin
                led_en  <= c_en_off;
                led_seg <= SEG_BLANK;
            end else begin
                led_en  <= ~w_sel;
                led_seg <= {~w_pattern, ~r_dp_q[r_idx]};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_driver
// Purpose  : Self-checking bench for seg_scan_driver (NUM_DIGITS=8,
//            SCAN_DIV=4). A frame-level reference model predicts led_en and
//            led_seg every cycle; directed steps add fixed expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;

    localparam int N  = 8;
    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] digits   = '0;
    logic [7:0]  digit_en = '0;
    logic [7:0]  dp       = '0;
    logic [7:0]  led_en;
    logic [7:0]  led_seg;

    seg_scan_driver #(
        .NUM_DIGITS (N),
        .SCAN_DIV   (SD),
        .DIV_W      (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .digits   (digits),
        .digit_en (digit_en),
        .dp       (dp),
        .led_en   (led_en),
        .led_seg  (led_seg)
    );

    always #5 clk = ~clk;

    // Segment table a..g, active high, written straight from the digit glyphs.
    logic [6:0] pat [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;      // clock edges since reset release
    logic [31:0] m_dig  = '0;     // snapshot shown in the current frame
    logic [7:0]  m_en   = '0;
    logic [7:0]  m_dp   = '0;
    logic [7:0]  exp_en;
    logic [7:0]  exp_seg;

    // Enables captured for a frame, including leading-zero suppression.
    function automatic logic [7:0] frame_en(input logic [31:0] d, input logic [7:0] e);
        logic [7:0] r;
        r = e;
`ifdef SEG_LEAD_ZERO_BLANK_EN
        begin
            int h;
            h = -1;   // highest visible non-zero digit
            for (int j = 0; j < N; j++) if (d[j*4 +: 4] != 4'h0 && e[j]) h = j;
            for (int i = 1; i < N; i++) if (d[i*4 +: 4] == 4'h0 && i > h) r[i] = 1'b0;
        end
`endif
        return r;
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: predict the outputs this edge produces, update the frame
    // snapshot if this edge ends a frame, then compare after the edge.
    task automatic step();
        int s, div, idx;
        @(posedge clk);
        if (rst) begin
            exp_en  = 8'hFF;
            exp_seg = 8'hFF;
        end else begin
            s   = cyc;
            div = s % SD;
            idx = (s / SD) % N;
            if (div == 0 || !m_en[idx]) begin
                exp_en  = 8'hFF;
                exp_seg = 8'hFF;
            end else begin
                exp_en  = ~(8'd1 << idx);
                exp_seg = {~pat[m_dig[idx*4 +: 4]], ~m_dp[idx]};
            end
            if (div == SD - 1 && idx == N - 1) begin
                m_dig = digits;
                m_en  = frame_en(digits, digit_en);
                m_dp  = dp;
            end
            cyc++;
        end
        #1;
        check("model_led_en", led_en, exp_en);
        check("model_led_seg", led_seg, exp_seg);
        checks++;
        assert ($countones(~led_en) <= 1)
        else begin
            errors++;
            $error("FAIL one_hot_en: observed %h expected at most one low bit", led_en);
        end
    endtask

    task automatic run_until(input int k);
        while (cyc < k) step();
    endtask

    initial begin
        // Reset held for a few cycles: everything dark.
        repeat (3) step();
        check("reset_led_en", led_en, 8'hFF);
        check("reset_led_seg", led_seg, 8'hFF);

        // Counter value 20 on digits 1:0.
        digits   = 32'h0000_0020;
        digit_en = 8'h03;
        dp       = 8'h00;
        rst      = 1'b0;
        run_until(32);
        check("first_frame_dark", led_en, 8'hFF);
        run_until(33);
        check("guard_slot0", led_en, 8'hFF);
        run_until(34);
        check("slot0_en", led_en, 8'hFE);
        check("slot0_seg_0", led_seg, 8'h03);

        // Change to 19 while digit 1 is being scanned.
        run_until(37);
        digits = 32'h0000_0019;
        run_until(38);
        check("slot1_en", led_en, 8'hFD);
        check("no_tear_seg_2", led_seg, 8'h25);
        run_until(42);
        check("slot2_dark", led_en, 8'hFF);
        run_until(66);
        check("next_frame_seg_9", led_seg, 8'h09);
        run_until(70);
        check("next_frame_seg_1", led_seg, 8'h9F);

        // Hex A with decimal point on digit 0, all digits enabled.
        digits   = 32'h8765_432A;
        digit_en = 8'hFF;
        dp       = 8'h01;
        run_until(98);
        check("dp_slot0_en", led_en, 8'hFE);
        check("dp_seg_A", led_seg, 8'h10);

        // Reset pulse in the middle of slot 5.
        run_until(118);
        check("slot5_en", led_en, 8'hDF);
        rst = 1'b1;
        cyc = 0;
        m_dig = '0;
        m_en  = '0;
        m_dp  = '0;
        #1;
        check("async_rst_en", led_en, 8'hFF);
        check("async_rst_seg", led_seg, 8'hFF);
        step();
        rst = 1'b0;
        run_until(33);
        check("post_rst_dark", led_en, 8'hFF);
        run_until(34);
        check("post_rst_slot0", led_en, 8'hFE);

        // Counter value 05, then 00.
        digits   = 32'h0000_0005;
        digit_en = 8'h03;
        dp       = 8'h00;
        run_until(66);
        check("val05_slot0", led_seg, 8'h49);
        run_until(70);
`ifdef SEG_LEAD_ZERO_BLANK_EN
        check("lead0_slot1_dark", led_en, 8'hFF);
`else
        check("val05_slot1_zero", led_seg, 8'h03);
`endif
        digits = 32'h0000_0000;
        run_until(98);
        check("val00_slot0", led_seg, 8'h03);
        run_until(102);
`ifdef SEG_LEAD_ZERO_BLANK_EN
        check("lead00_slot1_dark", led_en, 8'hFF);
`else
        check("val00_slot1_en", led_en, 8'hFD);
`endif

        // Random inputs changing at arbitrary cycles, checked by the model.
        for (int k = 0; k < 12 * N * SD; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                digits = $urandom;
                if ($urandom_range(0, 1) == 1) digits[31:16] = 16'h0000;
                if ($urandom_range(0, 2) == 0) digits[11:4]  = 8'h00;
                digit_en = 8'($urandom);
                dp       = 8'($urandom);
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
